fifo_sync_prog: RTL and testbench

FIFO_SYNC_PROG -- requirements
Module: fifo_sync_prog

---
 rtl/fifo_sync_prog.sv | 111 +++++++++++
 tb/tb_fifo_sync_prog.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty levels, sticky
// overflow/underflow flags and a selectable registered or fall-through read port.
module fifo_sync_prog #(
  parameter int depth = 8,
  parameter int width = 8,
  parameter int fwft  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [width-1:0]       data_in,
  input  logic                   rd_en,
  output logic [width-1:0]       data_out,
  output logic                   rd_valid,
  input  logic [$clog2(depth):0] af_thresh,
  input  logic [$clog2(depth):0] ae_thresh,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(depth):0] level,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);
  localparam int PW = $clog2(depth);
  localparam int LW = PW + 1;

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_ok, rd_ok;

  // Explicit wrap so non-power-of-two depths step correctly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full         = (level_q == LW'(depth));
    empty        = (level_q == '0);
    almost_full  = (level_q >= af_thresh);
    almost_empty = (level_q <= ae_thresh);
    level        = level_q;
    overflow     = ovf_q;
    underflow    = unf_q;
    // In fall-through mode a full FIFO can still take a write that replaces the popped head.
    wr_ok = wr_en && (!full || (rd_en && (fwft != 0) && !empty));
    rd_ok = rd_en && !empty;
    wr_ptr_d = wr_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // Error set wins over a same-cycle clear.
    ovf_d = (wr_en && !wr_ok) ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    unf_d = (rd_en && !rd_ok) ? 1'b1 : (err_clr ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_ptr_q] <= data_in;
  end

  if (fwft != 0) begin : g_fwft
    always_comb begin
      data_out = mem[rd_ptr_q];
      rd_valid = !empty;
    end
  end else begin : g_reg
    logic [width-1:0] dout_q, dout_d;
    logic             rvld_q, rvld_d;

    always_comb begin
      dout_d   = rd_ok ? mem[rd_ptr_q] : dout_q;
      rvld_d   = rd_ok;
      data_out = dout_q;
      rd_valid = rvld_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
        rvld_q <= 1'b0;
      end else begin
        dout_q <= dout_d;
        rvld_q <= rvld_d;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench: three FIFO instances (depth 8 registered, depth 5 registered,
// depth 4 fall-through) exercised by one task per scenario.
module tb_fifo_sync_prog;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // depth 8, registered read
  logic       r8, w8, re8, ec8, v8, f8, e8, afo8, aeo8, ov8, un8;
  logic [7:0] d8, q8;
  logic [3:0] af8, ae8, lv8;
  // depth 5, registered read
  logic       r5, w5, re5, ec5, v5, f5, e5, afo5, aeo5, ov5, un5;
  logic [7:0] d5, q5;
  logic [3:0] af5, ae5, lv5;
  // depth 4, fall-through
  logic       r4, w4, re4, ec4, v4, f4, e4, afo4, aeo4, ov4, un4;
  logic [7:0] d4, q4;
  logic [2:0] af4, ae4, lv4;

  fifo_sync_prog #(.depth(8), .width(8), .fwft(0)) u8 (
    .clk(clk), .rst(r8), .wr_en(w8), .data_in(d8), .rd_en(re8), .data_out(q8),
    .rd_valid(v8), .af_thresh(af8), .ae_thresh(ae8), .full(f8), .empty(e8),
    .almost_full(afo8), .almost_empty(aeo8), .level(lv8), .overflow(ov8),
    .underflow(un8), .err_clr(ec8));

  fifo_sync_prog #(.depth(5), .width(8), .fwft(0)) u5 (
    .clk(clk), .rst(r5), .wr_en(w5), .data_in(d5), .rd_en(re5), .data_out(q5),
    .rd_valid(v5), .af_thresh(af5), .ae_thresh(ae5), .full(f5), .empty(e5),
    .almost_full(afo5), .almost_empty(aeo5), .level(lv5), .overflow(ov5),
    .underflow(un5), .err_clr(ec5));

  fifo_sync_prog #(.depth(4), .width(8), .fwft(1)) u4 (
    .clk(clk), .rst(r4), .wr_en(w4), .data_in(d4), .rd_en(re4), .data_out(q4),
    .rd_valid(v4), .af_thresh(af4), .ae_thresh(ae4), .full(f4), .empty(e4),
    .almost_full(afo4), .almost_empty(aeo4), .level(lv4), .overflow(ov4),
    .underflow(un4), .err_clr(ec4));

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    r8 = 1'b1; r5 = 1'b1; r4 = 1'b1;
    tick(); tick();
    r8 = 1'b0; r5 = 1'b0; r4 = 1'b0;
    checks++; if (lv8 !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", lv8); end
    checks++; if (e8 !== 1'b1 || f8 !== 1'b0) begin errors++; $display("FAIL reset_empty_full got e=%b f=%b exp e=1 f=0", e8, f8); end
    checks++; if (v8 !== 1'b0 || q8 !== 8'h00) begin errors++; $display("FAIL reset_rdata got v=%b d=%h exp v=0 d=00", v8, q8); end
    checks++; if (ov8 !== 1'b0 || un8 !== 1'b0) begin errors++; $display("FAIL reset_err got ov=%b un=%b exp 0 0", ov8, un8); end
    checks++; if (e5 !== 1'b1 || lv5 !== 4'd0) begin errors++; $display("FAIL reset_d5 got e=%b lv=%0d exp e=1 lv=0", e5, lv5); end
    checks++; if (v4 !== 1'b0 || e4 !== 1'b1) begin errors++; $display("FAIL reset_fwft got v=%b e=%b exp v=0 e=1", v4, e4); end
  endtask

  task automatic test_fill_drain();
    checks++; if (aeo8 !== 1'b1 || afo8 !== 1'b0) begin errors++; $display("FAIL thresh_lvl0 got ae=%b af=%b exp ae=1 af=0", aeo8, afo8); end
    for (int i = 0; i < 8; i++) begin
      w8 = 1'b1; d8 = 8'h11 + 8'(i);
      tick();
      checks++; if (lv8 !== 4'(i + 1)) begin errors++; $display("FAIL fill_level got %0d exp %0d", lv8, i + 1); end
      checks++; if (aeo8 !== ((i + 1) <= 1)) begin errors++; $display("FAIL almost_empty lvl %0d got %b exp %b", i + 1, aeo8, (i + 1) <= 1); end
      checks++; if (afo8 !== ((i + 1) >= 6)) begin errors++; $display("FAIL almost_full lvl %0d got %b exp %b", i + 1, afo8, (i + 1) >= 6); end
    end
    w8 = 1'b0;
    checks++; if (f8 !== 1'b1) begin errors++; $display("FAIL full_at_8 got %b exp 1", f8); end
    af8 = 4'd9; #1;
    checks++; if (afo8 !== 1'b0) begin errors++; $display("FAIL live_af_thresh got %b exp 0", afo8); end
    af8 = 4'd6;
    w8 = 1'b1; d8 = 8'h99;
    tick();
    w8 = 1'b0;
    checks++; if (ov8 !== 1'b1 || lv8 !== 4'd8) begin errors++; $display("FAIL overflow got ov=%b lv=%0d exp ov=1 lv=8", ov8, lv8); end
    for (int i = 0; i < 8; i++) begin
      re8 = 1'b1;
      tick();
      re8 = 1'b0;
      checks++; if (q8 !== 8'h11 + 8'(i) || v8 !== 1'b1) begin errors++; $display("FAIL drain_data got d=%h v=%b exp d=%h v=1", q8, v8, 8'h11 + 8'(i)); end
      tick();
      checks++; if (v8 !== 1'b0 || q8 !== 8'h11 + 8'(i)) begin errors++; $display("FAIL drain_hold got d=%h v=%b exp d=%h v=0", q8, v8, 8'h11 + 8'(i)); end
    end
    checks++; if (e8 !== 1'b1 || lv8 !== 4'd0) begin errors++; $display("FAIL drain_empty got e=%b lv=%0d exp e=1 lv=0", e8, lv8); end
  endtask

  task automatic test_underflow();
    ec8 = 1'b1; tick(); ec8 = 1'b0;
    checks++; if (ov8 !== 1'b0 || un8 !== 1'b0) begin errors++; $display("FAIL err_clr got ov=%b un=%b exp 0 0", ov8, un8); end
    re8 = 1'b1; tick(); re8 = 1'b0;
    checks++; if (un8 !== 1'b1 || lv8 !== 4'd0 || v8 !== 1'b0 || q8 !== 8'h18) begin errors++; $display("FAIL underflow got un=%b lv=%0d v=%b d=%h exp un=1 lv=0 v=0 d=18", un8, lv8, v8, q8); end
    ec8 = 1'b1; tick(); ec8 = 1'b0;
    checks++; if (un8 !== 1'b0) begin errors++; $display("FAIL underflow_clr got %b exp 0", un8); end
    ec8 = 1'b1; re8 = 1'b1; tick(); ec8 = 1'b0; re8 = 1'b0;
    checks++; if (un8 !== 1'b1) begin errors++; $display("FAIL set_over_clr got %b exp 1", un8); end
    ec8 = 1'b1; tick(); ec8 = 1'b0;
    w8 = 1'b1; re8 = 1'b1; d8 = 8'h5A; tick(); w8 = 1'b0; re8 = 1'b0;
    checks++; if (lv8 !== 4'd1 || v8 !== 1'b0 || un8 !== 1'b1) begin errors++; $display("FAIL empty_wr_rd got lv=%0d v=%b un=%b exp lv=1 v=0 un=1", lv8, v8, un8); end
    re8 = 1'b1; tick(); re8 = 1'b0;
    checks++; if (q8 !== 8'h5A || v8 !== 1'b1 || lv8 !== 4'd0) begin errors++; $display("FAIL empty_wr_readback got d=%h v=%b lv=%0d exp d=5a v=1 lv=0", q8, v8, lv8); end
    ec8 = 1'b1; tick(); ec8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [7] = '{8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h30};
    for (int i = 0; i < 8; i++) begin
      w8 = 1'b1; d8 = 8'h21 + 8'(i); tick();
    end
    w8 = 1'b1; re8 = 1'b1; d8 = 8'hEE; tick();
    checks++; if (lv8 !== 4'd7 || ov8 !== 1'b1 || q8 !== 8'h21 || v8 !== 1'b1) begin errors++; $display("FAIL full_wr_rd got lv=%0d ov=%b d=%h v=%b exp lv=7 ov=1 d=21 v=1", lv8, ov8, q8, v8); end
    d8 = 8'h30; tick();
    w8 = 1'b0;
    checks++; if (lv8 !== 4'd7 || q8 !== 8'h22) begin errors++; $display("FAIL mid_wr_rd got lv=%0d d=%h exp lv=7 d=22", lv8, q8); end
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (q8 !== exp_q[i] || v8 !== 1'b1) begin errors++; $display("FAIL b2b_read got d=%h v=%b exp d=%h v=1", q8, v8, exp_q[i]); end
    end
    re8 = 1'b0;
    checks++; if (e8 !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b exp 1", e8); end
    ec8 = 1'b1; tick(); ec8 = 1'b0;
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 6; i++) begin
      w8 = 1'b1; d8 = 8'h41 + 8'(i); tick();
    end
    w8 = 1'b0; re8 = 1'b1; tick(); re8 = 1'b0;
    checks++; if (lv8 !== 4'd5 || q8 !== 8'h41 || v8 !== 1'b1) begin errors++; $display("FAIL pre_rst got lv=%0d d=%h v=%b exp lv=5 d=41 v=1", lv8, q8, v8); end
    r8 = 1'b1; w8 = 1'b1; re8 = 1'b1; d8 = 8'h77; tick();
    r8 = 1'b0; w8 = 1'b0; re8 = 1'b0;
    checks++; if (lv8 !== 4'd0 || e8 !== 1'b1 || v8 !== 1'b0 || q8 !== 8'h00) begin errors++; $display("FAIL midstream_rst got lv=%0d e=%b v=%b d=%h exp lv=0 e=1 v=0 d=00", lv8, e8, v8, q8); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) begin
        w5 = 1'b1; d5 = 8'(r * 16 + j + 1); tick();
      end
      w5 = 1'b0;
      checks++; if (lv5 !== 4'd3) begin errors++; $display("FAIL wrap_level round %0d got %0d exp 3", r, lv5); end
      re5 = 1'b1;
      for (int j = 0; j < 3; j++) begin
        tick();
        checks++; if (q5 !== 8'(r * 16 + j + 1) || v5 !== 1'b1) begin errors++; $display("FAIL wrap_data got d=%h v=%b exp d=%h v=1", q5, v5, 8'(r * 16 + j + 1)); end
      end
      re5 = 1'b0;
      checks++; if (lv5 !== 4'd0 || e5 !== 1'b1) begin errors++; $display("FAIL wrap_empty round %0d got lv=%0d e=%b exp lv=0 e=1", r, lv5, e5); end
    end
  endtask

  task automatic test_fwft();
    logic [7:0] exp_q [3] = '{8'hA2, 8'hA3, 8'hAA};
    for (int i = 0; i < 4; i++) begin
      w4 = 1'b1; d4 = 8'hA0 + 8'(i); tick();
      if (i == 0) begin
        checks++; if (q4 !== 8'hA0 || v4 !== 1'b1) begin errors++; $display("FAIL fwft_first got d=%h v=%b exp d=a0 v=1", q4, v4); end
      end
    end
    w4 = 1'b0;
    checks++; if (f4 !== 1'b1 || lv4 !== 3'd4) begin errors++; $display("FAIL fwft_full got f=%b lv=%0d exp f=1 lv=4", f4, lv4); end
    w4 = 1'b1; re4 = 1'b1; d4 = 8'hAA; tick(); w4 = 1'b0; re4 = 1'b0;
    checks++; if (lv4 !== 3'd4 || ov4 !== 1'b0 || q4 !== 8'hA1) begin errors++; $display("FAIL fwft_full_wr_rd got lv=%0d ov=%b d=%h exp lv=4 ov=0 d=a1", lv4, ov4, q4); end
    for (int i = 0; i < 3; i++) begin
      re4 = 1'b1; tick(); re4 = 1'b0;
      checks++; if (q4 !== exp_q[i] || v4 !== 1'b1) begin errors++; $display("FAIL fwft_head got d=%h v=%b exp d=%h v=1", q4, v4, exp_q[i]); end
    end
    checks++; if (lv4 !== 3'd1) begin errors++; $display("FAIL fwft_level got %0d exp 1", lv4); end
    re4 = 1'b1; tick(); re4 = 1'b0;
    checks++; if (e4 !== 1'b1 || v4 !== 1'b0 || un4 !== 1'b0) begin errors++; $display("FAIL fwft_empty got e=%b v=%b un=%b exp e=1 v=0 un=0", e4, v4, un4); end
  endtask

  initial begin
    r8 = 1'b1; w8 = 1'b0; re8 = 1'b0; ec8 = 1'b0; d8 = '0; af8 = 4'd6; ae8 = 4'd1;
    r5 = 1'b1; w5 = 1'b0; re5 = 1'b0; ec5 = 1'b0; d5 = '0; af5 = 4'd4; ae5 = 4'd1;
    r4 = 1'b1; w4 = 1'b0; re4 = 1'b0; ec4 = 1'b0; d4 = '0; af4 = 3'd3; ae4 = 3'd1;
    test_reset();
    test_fill_drain();
    test_underflow();
    test_back_to_back();
    test_reset_midstream();
    test_wrap();
    test_fwft();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
